// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter: default bus widths,
// priority state encoding and read-return owner IDs.
package mem_bus_pkg;

  localparam int AW_DEF = 20;
  localparam int DW_DEF = 8;

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DMA = 1'b1
  } prio_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_prio_fsm.sv
// Priority state machine for the memory arbiter: tracks how long the DMA side has
// been refused and how long a forced DMA burst has run, and reports DMA priority.
module arb_prio_fsm
  import mem_bus_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_lock,
  input  logic dma_gnt,
  output logic prio_dma
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [BW-1:0] BURST_SAT  = BW'(BURST_MAX);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);

  prio_state_e     r_state, w_state_nxt;
  logic [WW-1:0]   r_wait_cnt, w_wait_nxt;
  logic [BW-1:0]   r_burst_cnt, w_burst_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= PRI_CPU;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_burst_nxt = r_burst_cnt;

    if (dma_req && !dma_gnt) begin
      if (r_wait_cnt != WAIT_SAT) w_wait_nxt = r_wait_cnt + WAIT_ONE;
    end else begin
      w_wait_nxt = '0;
    end

    case (r_state)
      PRI_CPU: begin
        // Last tolerated refusal: hand priority to DMA starting next cycle.
        if (dma_req && !dma_gnt && (r_wait_cnt == WAIT_LAST)) begin
          w_state_nxt = PRI_DMA;
          w_wait_nxt  = '0;
          w_burst_nxt = '0;
        end
      end
      PRI_DMA: begin
        if (!dma_req) begin
          w_state_nxt = PRI_CPU;
          w_burst_nxt = '0;
        end else if (dma_gnt) begin
          if (!dma_lock || (r_burst_cnt == BURST_LAST)) begin
            w_state_nxt = PRI_CPU;
            w_burst_nxt = '0;
          end else if (r_burst_cnt != BURST_SAT) begin
            w_burst_nxt = r_burst_cnt + BURST_ONE;
          end
        end
      end
      default: w_state_nxt = PRI_CPU;
    endcase
  end

  assign prio_dma = (r_state == PRI_DMA);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single-port system memory: CPU is default owner,
// DMA gets starvation-protected priority and short locked bursts.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_we,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic   w_prio_dma;
  owner_e w_owner_p0;
  owner_e r_owner_p1;

  arb_prio_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .BURST_MAX (BURST_MAX)
  ) u_prio_fsm (
    .clock    (clock),
    .reset    (reset),
    .dma_req  (dma_req),
    .dma_lock (dma_lock),
    .dma_gnt  (dma_gnt),
    .prio_dma (w_prio_dma)
  );

  // Stage p0: grant decision and memory request mux
  always_comb begin
    cpu_ready = 1'b0;
    dma_gnt   = 1'b0;
    if (w_prio_dma) begin
      dma_gnt   = dma_req;
      cpu_ready = cpu_req && !dma_req;
    end else begin
      cpu_ready = cpu_req;
      dma_gnt   = dma_req && !cpu_req;
    end
  end

  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = 1'b0;
    w_owner_p0 = OWN_NONE;
    if (cpu_ready) begin
      mem_we = cpu_we;
      if (!cpu_we) w_owner_p0 = OWN_CPU;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      if (!dma_we) w_owner_p0 = OWN_DMA;
    end
    // Grants still track requests in reset, but nothing may land in memory.
    if (reset) mem_we = 1'b0;
  end

  // Stage p1: read data return, aligned with the memory's one-cycle latency
  always_ff @(posedge clock) begin
    if (reset) r_owner_p1 <= OWN_NONE;
    else       r_owner_p1 <= w_owner_p0;
  end

  assign cpu_rvalid = (r_owner_p1 == OWN_CPU);
  assign dma_rvalid = (r_owner_p1 == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle expectations and read-data
// expectations are queued by the driver and checked by an independent monitor.
module tb_mem_bus_arbiter;

  localparam logic [19:0] CA = 20'h12345;
  localparam logic [19:0] DA = 20'h00400;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
  logic [19:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [19:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [0:1048575];

  typedef struct {
    logic [4:0]  exp;
    logic [19:0] addr;
    string       tag;
  } rec_t;

  rec_t       q_cyc[$];
  logic [7:0] q_cpu[$];
  logic [7:0] q_dma[$];
  int         n_chk = 0;
  int         n_fail = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Registered single-port memory with one-cycle read latency
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Monitor: checks each queued cycle record and every rvalid against the queues
  always @(negedge clock) begin
    rec_t       r;
    logic [4:0] got;
    logic [7:0] e;
    if (q_cyc.size() > 0) begin
      r   = q_cyc.pop_front();
      got = {cpu_ready, dma_gnt, mem_we, cpu_rvalid, dma_rvalid};
      n_chk++;
      if (got !== r.exp || mem_addr !== r.addr) begin
        n_fail++;
        $display("FAIL %s rdy/gnt/we/crv/drv=%b addr=%h, expected %b addr=%h",
                 r.tag, got, mem_addr, r.exp, r.addr);
      end
    end
    if (cpu_rvalid === 1'b1) begin
      n_chk++;
      if (q_cpu.size() == 0) begin
        n_fail++;
        $display("FAIL cpu_rvalid_unexpected data=%h, expected no response", cpu_rdata);
      end else begin
        e = q_cpu.pop_front();
        if (cpu_rdata !== e) begin
          n_fail++;
          $display("FAIL cpu_rdata got %h, expected %h", cpu_rdata, e);
        end
      end
    end
    if (dma_rvalid === 1'b1) begin
      n_chk++;
      if (q_dma.size() == 0) begin
        n_fail++;
        $display("FAIL dma_rvalid_unexpected data=%h, expected no response", dma_rdata);
      end else begin
        e = q_dma.pop_front();
        if (dma_rdata !== e) begin
          n_fail++;
          $display("FAIL dma_rdata got %h, expected %h", dma_rdata, e);
        end
      end
    end
  end

  // One cycle of stimulus; exp = {cpu_ready, dma_gnt, mem_we, cpu_rvalid, dma_rvalid}
  task automatic cyc(input logic rst, input logic cr, input logic cw, input logic [19:0] ca,
                     input logic [7:0] cd, input logic dr, input logic dl, input logic dw,
                     input logic [19:0] da, input logic [7:0] dd, input logic [4:0] exp,
                     input logic [19:0] ea, input logic [7:0] erd, input string tag);
    @(posedge clock);
    #1;
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_lock = dl; dma_we = dw; dma_addr = da; dma_wdata = dd;
    q_cyc.push_back('{exp, ea, tag});
    if (!rst && exp[4] && !cw) q_cpu.push_back(erd);
    if (!rst && exp[3] && !dw) q_dma.push_back(erd);
  endtask

  task automatic idle(input logic [19:0] ca, input logic [4:0] exp, input string tag);
    cyc(1'b0, 1'b0, 1'b0, ca, 8'h00, 1'b0, 1'b0, 1'b0, 20'h0, 8'h00, exp, ca, 8'h00, tag);
  endtask

  // Both sides reading: CPU at CA (0x3C), DMA at DA (0xA5)
  task automatic both(input logic rst, input logic lock, input logic [4:0] exp, input string tag);
    cyc(rst, 1'b1, 1'b0, CA, 8'h00, 1'b1, lock, 1'b0, DA, 8'h00, exp,
        exp[3] ? DA : CA, exp[3] ? 8'hA5 : 8'h3C, tag);
  endtask

  initial begin
    mem[CA] = 8'h3C;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    cyc(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 5'b00000, 20'h0, 8'h0, "reset_state");
    cyc(1'b1, 1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0, 5'b00000, 20'h0, 8'h0, "reset_state2");

    for (int i = 0; i < 10; i++) idle(20'(i * 20'h111), 5'b00000, "idle");

    cyc(1'b0, 1'b1, 1'b0, CA, 8'h00, 1'b0, 1'b0, 1'b0, 20'h0ABCD, 8'h00, 5'b10000, CA, 8'h3C, "cpu_rd");
    idle(20'h0, 5'b00010, "cpu_rvalid");

    cyc(1'b0, 1'b1, 1'b1, DA, 8'hA5, 1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 5'b10100, DA, 8'h00, "cpu_wr");
    cyc(1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, DA, 8'h00, 5'b01000, DA, 8'hA5, "dma_rd_after_wr");
    idle(20'h0, 5'b00001, "dma_rvalid_only");

    both(1'b0, 1'b0, 5'b10000, "cont_cpu1");
    for (int i = 0; i < 3; i++) both(1'b0, 1'b0, 5'b10010, "cont_cpu");
    both(1'b0, 1'b0, 5'b01010, "cont_dma_5th");
    both(1'b0, 1'b0, 5'b10001, "cont_cpu_regain");
    for (int i = 0; i < 3; i++) both(1'b0, 1'b0, 5'b10010, "cont_cpu_rep");
    both(1'b0, 1'b0, 5'b01010, "cont_dma_rep");
    idle(20'h0, 5'b00001, "cont_end");

    both(1'b0, 1'b1, 5'b10000, "burst_wait1");
    for (int i = 0; i < 3; i++) both(1'b0, 1'b1, 5'b10010, "burst_wait");
    both(1'b0, 1'b1, 5'b01010, "burst_gnt1");
    for (int i = 0; i < 7; i++) both(1'b0, 1'b1, 5'b01001, "burst_gnt");
    both(1'b0, 1'b1, 5'b10001, "burst_cpu_back");
    both(1'b0, 1'b1, 5'b10010, "burst_cpu_keep");
    idle(20'h0, 5'b00010, "burst_end");

    both(1'b0, 1'b1, 5'b10000, "rstb_wait1");
    for (int i = 0; i < 3; i++) both(1'b0, 1'b1, 5'b10010, "rstb_wait");
    both(1'b0, 1'b1, 5'b01010, "rstb_gnt1");
    both(1'b0, 1'b1, 5'b01001, "rstb_gnt2");
    both(1'b1, 1'b1, 5'b01001, "rstb_gnt3_reset");
    both(1'b0, 1'b1, 5'b10000, "rstb_cpu_prio_no_rvalid");
    idle(20'h0, 5'b00010, "rstb_end");

    cyc(1'b1, 1'b1, 1'b1, DA, 8'h77, 1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 5'b10000, DA, 8'h00, "reset_blocks_we");
    cyc(1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, DA, 8'h00, 5'b01000, DA, 8'hA5, "mem_unchanged");
    idle(20'h0, 5'b00001, "mem_unchanged_rv");

    cyc(1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 1'b1, 1'b0, 1'b1, 20'h00800, 8'h5A, 5'b01100, 20'h00800, 8'h00, "dma_wr");
    cyc(1'b0, 1'b1, 1'b0, 20'h00800, 8'h00, 1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 5'b10000, 20'h00800, 8'h5A, "cpu_rd_dma_data");
    idle(20'h0, 5'b00010, "final_rv");
    idle(20'h0, 5'b00000, "final_idle");

    repeat (2) @(negedge clock);
    #1;
    n_chk++;
    if (q_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL cycle_queue_drain left %0d, expected 0", q_cyc.size());
    end
    n_chk++;
    if (q_cpu.size() != 0) begin
      n_fail++;
      $display("FAIL cpu_resp_missing left %0d, expected 0", q_cpu.size());
    end
    n_chk++;
    if (q_dma.size() != 0) begin
      n_fail++;
      $display("FAIL dma_resp_missing left %0d, expected 0", q_dma.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
